// File: rtl/vec_mul_arb.sv
// Round-robin arbiter feeding a two-stage pipeline around a shared lane-wise
// small-float multiplier array; products are tagged with the winning requester.
module vec_mul_arb #(
  parameter int unsigned exp_width = 5,
  parameter int unsigned man_width = 2,
  parameter int unsigned length    = 32,
  parameter int unsigned n_req     = 2,
  localparam int unsigned bit_width = 1 + exp_width + man_width,
  localparam int unsigned fx_width  = (1 << exp_width) + man_width + 2,
  localparam int unsigned prd_width = 2 * fx_width,
  localparam int unsigned id_width  = (n_req > 1) ? $clog2(n_req) : 1
) (
  input  logic                                          i_clk,
  input  logic                                          i_rst,
  input  logic [n_req-1:0]                              i_req_valid,
  output logic [n_req-1:0]                              o_req_ready,
  input  logic [n_req-1:0][length-1:0][bit_width-1:0]   i_vec_a,
  input  logic [n_req-1:0][length-1:0][bit_width-1:0]   i_vec_b,
  output logic                                          o_valid,
  input  logic                                          i_ready,
  output logic [id_width-1:0]                           o_id,
  output logic [length-1:0][prd_width-1:0]              o_prd,
  output logic                                          o_idle
);

  // Element to signed fixed point: {hidden, mantissa} shifted by (exp-1);
  // exponent 0 is subnormal (hidden bit 0, no shift).
  function automatic logic signed [fx_width-1:0] to_fixed(input logic [bit_width-1:0] x);
    logic [exp_width-1:0] e;
    logic [fx_width-1:0]  mag;
    e   = x[bit_width-2 -: exp_width];
    mag = fx_width'({(e != '0), x[man_width-1:0]});
    if (e != '0) mag = mag << (e - exp_width'(1));
    return x[bit_width-1] ? -mag : mag;
  endfunction

  function automatic logic signed [prd_width-1:0] mul_fp6(input logic [bit_width-1:0] a,
                                                           input logic [bit_width-1:0] b);
    logic signed [prd_width-1:0] pa;
    logic signed [prd_width-1:0] pb;
    pa = prd_width'(to_fixed(a));
    pb = prd_width'(to_fixed(b));
    return pa * pb;
  endfunction

  logic                                  s1_valid_q, s1_valid_d;
  logic [length-1:0][bit_width-1:0]      s1_a_q, s1_a_d;
  logic [length-1:0][bit_width-1:0]      s1_b_q, s1_b_d;
  logic [id_width-1:0]                   s1_id_q, s1_id_d;
  logic [id_width-1:0]                   ptr_q, ptr_d;
  logic                                  o_valid_q, o_valid_d;
  logic [id_width-1:0]                   o_id_q, o_id_d;
  logic [length-1:0][prd_width-1:0]      o_prd_q, o_prd_d;

  logic                                  out_en_c;
  logic                                  s1_en_c;
  logic                                  any_c;
  logic [id_width-1:0]                   grant_c;
  logic [length-1:0][prd_width-1:0]      s1_prd_c;

  // Round-robin search: first valid at or above ptr, else first valid below it.
  always_comb begin
    any_c   = 1'b0;
    grant_c = '0;
    for (int r = 0; r < int'(n_req); r++) begin
      if (!any_c && i_req_valid[r] && (r >= int'(ptr_q))) begin
        any_c   = 1'b1;
        grant_c = id_width'(r);
      end
    end
    for (int r = 0; r < int'(n_req); r++) begin
      if (!any_c && i_req_valid[r] && (r < int'(ptr_q))) begin
        any_c   = 1'b1;
        grant_c = id_width'(r);
      end
    end
  end

  always_comb begin
    out_en_c = !o_valid_q || i_ready;
    s1_en_c  = !s1_valid_q || out_en_c;
  end

  // Ready is forced low while reset is asserted so requesters see it drop at once.
  always_comb begin
    o_req_ready = '0;
    for (int r = 0; r < int'(n_req); r++) begin
      o_req_ready[r] = !i_rst && s1_en_c && any_c && (grant_c == id_width'(r));
    end
  end

  always_comb begin
    for (int i = 0; i < int'(length); i++) begin
      s1_prd_c[i] = mul_fp6(s1_a_q[i], s1_b_q[i]);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    ptr_d      = ptr_q;
    o_valid_d  = o_valid_q;
    o_id_d     = o_id_q;
    o_prd_d    = o_prd_q;

    if (out_en_c) begin
      o_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        o_prd_d = s1_prd_c;
        o_id_d  = s1_id_q;
      end
    end

    if (s1_en_c) begin
      s1_valid_d = any_c;
      if (any_c) begin
        for (int r = 0; r < int'(n_req); r++) begin
          if (grant_c == id_width'(r)) begin
            s1_a_d = i_vec_a[r];
            s1_b_d = i_vec_b[r];
          end
        end
        s1_id_d = grant_c;
        ptr_d   = (grant_c == id_width'(n_req - 1)) ? '0 : grant_c + id_width'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      ptr_q      <= '0;
      o_valid_q  <= 1'b0;
      o_id_q     <= '0;
      o_prd_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      ptr_q      <= ptr_d;
      o_valid_q  <= o_valid_d;
      o_id_q     <= o_id_d;
      o_prd_q    <= o_prd_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_id    = o_id_q;
  assign o_prd   = o_prd_q;
  assign o_idle  = !s1_valid_q && !o_valid_q;

endmodule

// File: doc/vec_mul_arb.md
Name: vec_mul_arb

Overview:
- Round-robin arbiter and two-stage pipeline that shares one elementwise FP multiplier array (mul_fp6 per lane, as in vec_mul_fp6) among n_req requesters.
- Each requester presents a pair of operand vectors with a valid/ready handshake.
- Granted vectors are registered, multiplied lane-wise, and presented on one output channel tagged with the requester id.
- Sits between the MX block-producing front ends and the dot-product/accumulate stage.

Parameters:
- exp_width, 5, exponent bits of each element.
- man_width, 2, mantissa bits of each element.
- length, 32, lanes per vector.
- n_req, 2, number of requesters (range 2..8).
- bit_width, 1+exp_width+man_width, element width (derived).
- prd_width, 2*((1<<exp_width)+man_width+2), fixed-point product width per lane (derived; matches mul_fp6).
- id_width, max(1,$clog2(n_req)), requester tag width (derived).

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req_valid  in  [n_req]  requester r has an operand pair.
- o_req_ready  out  [n_req]  requester r's pair is accepted this cycle.
- i_vec_a  in  [n_req][length] x bit_width  operand A vectors, signed.
- i_vec_b  in  [n_req][length] x bit_width  operand B vectors, signed.
- o_valid  out  1  output product vector valid.
- i_ready  in  1  downstream accepts the output.
- o_id  out  id_width  requester index of the output vector.
- o_prd  out  [length] x prd_width  lane products, signed.
- o_idle  out  1  no vector in flight (s1 and output empty).

Behaviour:
- Reset (async assert, sync release):
  - s1_valid=0, o_valid=0, o_id=0, o_prd all 0, rr pointer=0, o_req_ready all 0.
  - Assertion mid-operation discards everything in flight; nothing is replayed.
- Pipeline:
  - S1 register holds the granted A, B and id.
  - The mul_fp6 array is combinational on S1.
  - The output register holds products and id.
- Enables:
  - out_en = !o_valid || i_ready.
  - s1_en = !s1_valid || out_en.
- Output register:
  - On out_en, o_valid <= s1_valid, and o_prd/o_id <= S1 products/id when s1_valid.
  - When !out_en, o_prd/o_id/o_valid hold stable.
- Latency and throughput:
  - Handshake at edge k: o_valid is high after edge k+1, i.e. 2 cycles from request to output.
  - Throughput is 1 vector/cycle with i_ready held high.
- Arbitration:
  - Combinational; depends only on i_req_valid and rr pointer, never on i_ready.
  - grant = first r with i_req_valid[r], searching r = ptr, ptr+1, ... mod n_req.
  - o_req_ready[r] = s1_en && any valid && grant==r; at most one bit is set.
  - On accept: S1 <= granted vectors, id <= grant, s1_valid <= 1, ptr <= (grant+1) mod n_req.
  - If s1_en and no request: s1_valid <= 0 and ptr holds.
  - ptr never changes without an accept; wrap from n_req-1 to 0.
- Requester contract:
  - Hold valid and data stable until ready.
  - Requesters may drop valid only after a handshake.
  - The block never accepts a requester whose valid is low.
- Backpressure:
  - With o_valid and S1 full and i_ready=0, all o_req_ready stay 0 and nothing is overwritten.
  - When i_ready rises, output, S1 and a new accept all advance in the same cycle.
- Arithmetic: o_prd[i] is bit-exact with mul_fp6(A[i],B[i]) for every lane; no rounding or saturation in this block.
- o_idle = !s1_valid && !o_valid.

Test Plan:
- Reset then requester 0 only: i_vec_a lanes=0x3C (1.0 e5m2), i_vec_b lanes=0x40 (2.0).
  - o_req_ready[0]=1 in cycle 0; o_valid=1 two cycles later.
  - o_id=0; every o_prd lane equals the mul_fp6 model value for 1.0*2.0.
  - o_idle returns to 1 after drain.
- Both requesters valid continuously, i_ready=1, n_req=2:
  - Grants alternate 0,1,0,1.
  - o_id alternates 0,1,0,1 at 1 vector/cycle.
  - Each pair is accepted exactly once per handshake.
- Both valid, i_ready=0 for 5 cycles:
  - Exactly 2 accepts occur, then o_req_ready=0.
  - o_prd/o_id stay stable.
  - On i_ready=1, outputs drain in accept order with no loss or duplicate.
- n_req=4, only requesters 1 and 3 valid, ptr=2 after the prior grant of 1:
  - Next grant is 3, then 1 (wrap).
  - Requesters 0 and 2 never see ready.
- Lane corners: a lane with 0x00, a negative lane 0xBC (-1.0), and a max-normal lane 0x7B:
  - Each lane matches the mul_fp6 model bit-exactly, sign included.
- Assert i_rst while S1 and output are full:
  - o_valid, o_req_ready and o_idle reflect reset immediately (async).
  - ptr=0 after release; the first post-reset grant goes to requester 0 when all are valid.
